// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: read-mode enum,
// default sizing constants and the power-of-two check used at elaboration.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD,
        FIFO_FWFT
    } fifo_mode_e;

    localparam int FIFO_DATA_W = 32;
    localparam int FIFO_DEPTH  = 16;

    function automatic bit isPow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port and one
// asynchronous read address. Contents are deliberately not reset.
module fifo_mem #(
    parameter int DATA  = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [DATA-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [DATA-1:0] rdata
);

    logic [DATA-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, programmable almost-full/empty
// thresholds, sticky overflow/underflow flags and selectable FWFT read mode.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA   = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int AFULL  = DEPTH - 2,
    parameter int AEMPTY = 2,
    parameter int FWFT   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write,
    input  logic [DATA-1:0]          wdata,
    output logic                     wfull,
    output logic                     walmost_full,
    input  logic                     read,
    output logic [DATA-1:0]          rdata,
    output logic                     rempty,
    output logic                     ralmost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clear_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    if (!isPow2(DEPTH) || DEPTH < 4) begin : g_badDepth
        $error("sync_fifo_param: DEPTH must be a power of two >= 4");
    end
    if (!(AEMPTY > 0 && AEMPTY < AFULL && AFULL < DEPTH)) begin : g_badThresh
        $error("sync_fifo_param: need 0 < AEMPTY < AFULL < DEPTH");
    end

    logic [CW-1:0]   r_wptr, r_rptr, r_count;
    logic [CW-1:0]   w_wptrNext, w_rptrNext, w_countNext;
    logic            r_wfull, r_walmostFull, r_rempty, r_ralmostEmpty;
    logic            r_overflow, r_underflow;
    logic            w_wrAccept, w_rdAccept;
    logic [DATA-1:0] w_memRdata;

    // A write into a full FIFO is refused even if a read frees a slot this cycle.
    assign w_wrAccept  = write && !r_wfull;
    assign w_rdAccept  = read && !r_rempty;
    assign w_wptrNext  = r_wptr + CW'(w_wrAccept);
    assign w_rptrNext  = r_rptr + CW'(w_rdAccept);
    assign w_countNext = w_wptrNext - w_rptrNext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_wfull        <= 1'b0;
            r_walmostFull  <= 1'b0;
            r_rempty       <= 1'b1;
            r_ralmostEmpty <= 1'b1;
        end else begin
            r_wptr         <= w_wptrNext;
            r_rptr         <= w_rptrNext;
            r_count        <= w_countNext;
            r_wfull        <= (w_countNext == CW'(DEPTH));
            r_walmostFull  <= (w_countNext >= CW'(AFULL));
            r_rempty       <= (w_countNext == '0);
            r_ralmostEmpty <= (w_countNext <= CW'(AEMPTY));
        end
    end

    // Sticky error flags; a new error wins over a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (write && r_wfull) begin
                r_overflow <= 1'b1;
            end else if (clear_err) begin
                r_overflow <= 1'b0;
            end
            if (read && r_rempty) begin
                r_underflow <= 1'b1;
            end else if (clear_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .DATA  (DATA),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_wrAccept),
        .waddr (r_wptr[AW-1:0]),
        .wdata (wdata),
        .raddr (r_rptr[AW-1:0]),
        .rdata (w_memRdata)
    );

    if (MODE == FIFO_FWFT) begin : g_fwft
        assign rdata = w_memRdata;
    end else begin : g_std
        logic [DATA-1:0] r_rdata;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_rdata <= '0;
            end else if (w_rdAccept) begin
                r_rdata <= w_memRdata;
            end
        end

        assign rdata = r_rdata;
    end

    assign wfull         = r_wfull;
    assign walmost_full  = r_walmostFull;
    assign rempty        = r_rempty;
    assign ralmost_empty = r_ralmostEmpty;
    assign count         = r_count;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

endmodule
